// File: rtl/unbuff_pkg.sv
// unbuff_pkg: shared types and elaboration helpers for the unbuff deserializer.
// Provides the FSM state enum, the chunk-count helper and the counter-width helper.
// No ports; imported by rtl/unbuff.sv.
package unbuff_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  // Number of BITS-wide chunks that make up one DATA_BITS word.
  function automatic int count_of(input int data_bits, input int bits);
    return data_bits / bits;
  endfunction

  // Chunk counter width: one spare bit above what COUNT needs.
  function automatic int cnt_width(input int count);
    return $clog2(count) + 1;
  endfunction

endpackage

// File: rtl/unbuff.sv
// unbuff: deserializer that reassembles COUNT = DATA_BITS/BITS chunks (MSB chunk first) into one word.
// Latency: word_valid pulses one cycle after the last chunk is sampled (COUNT cycles after start_in without stalls).
// Backpressure: none toward the source; optional macro UNBUFF_STALL_EN adds b_valid to hold collection while low.
// Ports: clk, rst_n (sync, active-low), start_in, b_in[BITS], [b_valid], word_out[DATA_BITS], word_valid, busy, resync_err.
module unbuff
  import unbuff_pkg::*;
#(
  parameter int DATA_BITS = 64,
  parameter int BITS      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_in,
  input  logic [BITS-1:0]      b_in,
`ifdef UNBUFF_STALL_EN
  input  logic                 b_valid,
`endif
  output logic [DATA_BITS-1:0] word_out,
  output logic                 word_valid,
  output logic                 busy,
  output logic                 resync_err
);

  localparam int COUNT = count_of(DATA_BITS, BITS);
  localparam int CW    = cnt_width(COUNT);
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  generate
    if ((DATA_BITS % BITS) != 0 || COUNT < 2 || COUNT > 256) begin : g_bad_params
      $error("unbuff: DATA_BITS must be a multiple of BITS with 2 <= DATA_BITS/BITS <= 256");
    end
  endgenerate

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [DATA_BITS-1:0]   word_q, word_d;
  logic                   valid_q, valid_d;
  logic                   rerr_q, rerr_d;
  logic                   busy_q;
  logic                   accept;
  logic [DATA_BITS-1:0]   first_word;
  logic [DATA_BITS-1:0]   shifted_word;

`ifdef UNBUFF_STALL_EN
  assign accept = b_valid;
`else
  assign accept = 1'b1;
`endif

  // Chunk 0 lands in the low bits; later chunks push it upward toward the MSB.
  assign first_word   = {{(DATA_BITS-BITS){1'b0}}, b_in};
  assign shifted_word = {shreg_q[DATA_BITS-BITS-1:0], b_in};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    valid_d = 1'b0;
    rerr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          shreg_d = first_word;
          cnt_d   = CW'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        // A new start wins over everything, including the final chunk of the current frame.
        if (start_in) begin
          shreg_d = first_word;
          cnt_d   = CW'(1);
          rerr_d  = 1'b1;
        end else if (accept) begin
          shreg_d = shifted_word;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            word_d  = shifted_word;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        shreg_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      rerr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      rerr_q  <= rerr_d;
      // Registered from next state so busy tracks the state register exactly.
      busy_q  <= (state_d == COLLECT);
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign busy       = busy_q;
  assign resync_err = rerr_q;

endmodule

// File: tb/tb_unbuff.sv
// tb_unbuff: table-driven bench for unbuff with a scoreboard of expected words.
// Each vector is applied on the falling edge and its outputs checked 1 time unit after the next rising edge.
// Expected words are queued when the final chunk is driven and popped when word_valid is seen.
module tb_unbuff;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_in;
  logic [7:0]  b_in;
  logic        b_valid;
  logic [63:0] word_out;
  logic        word_valid;
  logic        busy;
  logic        resync_err;

  always #5 clk = ~clk;

  unbuff #(.DATA_BITS(64), .BITS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_in   (start_in),
    .b_in       (b_in),
`ifdef UNBUFF_STALL_EN
    .b_valid    (b_valid),
`endif
    .word_out   (word_out),
    .word_valid (word_valid),
    .busy       (busy),
    .resync_err (resync_err)
  );

  typedef struct {
    logic        rst_n;
    logic        start;
    logic [7:0]  b;
    logic        bv;
    logic        exp_busy;
    logic        exp_vld;
    logic        exp_rerr;
    logic        push;
    logic [63:0] word;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] sb[$];
  logic [63:0] exp_word;
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic s, input logic [7:0] b, input logic bv,
                     input logic eb, input logic ev, input logic er,
                     input logic p, input logic [63:0] w);
    vec_t v;
    v.rst_n = r; v.start = s; v.b = b; v.bv = bv;
    v.exp_busy = eb; v.exp_vld = ev; v.exp_rerr = er; v.push = p; v.word = w;
    vecs.push_back(v);
  endtask

  // First n chunks of w (start on chunk 0); frame left incomplete.
  task automatic add_partial(input logic [63:0] w, input int n, input logic rerr_first);
    for (int i = 0; i < n; i++)
      add(1'b1, i == 0, w[63-8*i -: 8], 1'b1, 1'b1, 1'b0, rerr_first && i == 0, 1'b0, 64'h0);
  endtask

  // Full frame: busy after chunks 0..6, word_valid after chunk 7.
  task automatic add_frame(input logic [63:0] w, input logic rerr_first);
    add_partial(w, 7, rerr_first);
    add(1'b1, 1'b0, w[7:0], 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, w);
  endtask

  task automatic add_idle(input logic [7:0] b);
    add(1'b1, 1'b0, b, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic add_reset(input logic s, input logic [7:0] b);
    add(1'b0, s, b, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst_n    = v.rst_n;
    start_in = v.start;
    b_in     = v.b;
    b_valid  = v.bv;
    if (v.push) sb.push_back(v.word);
    @(posedge clk);
    #1;
    if (!v.rst_n) exp_word = 64'h0;
    else if (v.exp_vld) exp_word = v.word;
    chk("busy", {63'h0, busy}, {63'h0, v.exp_busy});
    chk("word_valid", {63'h0, word_valid}, {63'h0, v.exp_vld});
    chk("resync_err", {63'h0, resync_err}, {63'h0, v.exp_rerr});
    chk("word_out_hold", word_out, exp_word);
    if (word_valid === 1'b1) begin
      if (sb.size() == 0) chk("sb_unexpected_word", word_out, 64'hx);
      else chk("sb_word", word_out, sb.pop_front());
    end
  endtask

  initial begin
    rst_n = 1'b0; start_in = 1'b0; b_in = 8'h00; b_valid = 1'b1;
    exp_word = 64'h0;

    // Reset state.
    add_reset(1'b0, 8'h00);
    add_reset(1'b0, 8'h00);
    add_idle(8'h99);
    // Basic frame, then idle cycles with garbage data to show word_out holds.
    add_frame(64'h0102030405060708, 1'b0);
    add_idle(8'h00);
    add_idle(8'h5A);
    // Resync: start + 3 chunks, then a new start.
    add_partial(64'hAAABACAD00000000, 4, 1'b0);
    add_frame(64'h1112131415161718, 1'b1);
    add_idle(8'h00);
    // Reset mid-frame; reset overrides a start_in.
    add_partial(64'h5152535455565758, 4, 1'b0);
    add_reset(1'b0, 8'h55);
    add_reset(1'b1, 8'h56);
    add_frame(64'hF0F1F2F3F4F5F6F7, 1'b0);
    add_idle(8'h00);
    // Buff-style stream: each word followed by its trailing zero chunk.
    add_frame(64'hDEADBEEFCAFEF00D, 1'b0);
    add_idle(8'h00);
    add_frame(64'h0123456789ABCDEF, 1'b0);
    add_idle(8'h00);
    // Back-to-back: next start on the word_valid cycle.
    add_frame(64'hA0A1A2A3A4A5A6A7, 1'b0);
    add_frame(64'hB0B1B2B3B4B5B6B7, 1'b0);
    add_idle(8'h00);
    // start_in on the final-chunk cycle.
    add_partial(64'h2122232425262728, 7, 1'b0);
    add_frame(64'h3132333435363738, 1'b1);
    add_idle(8'h00);
`ifdef UNBUFF_STALL_EN
    // Stalls of 2 cycles after chunks 2 and 5.
    add(1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    add(1'b1, 1'b0, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    add(1'b1, 1'b0, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    add(1'b1, 1'b0, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    add(1'b1, 1'b0, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    add(1'b1, 1'b0, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    add(1'b1, 1'b0, 8'h05, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    add(1'b1, 1'b0, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    add(1'b1, 1'b0, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    add(1'b1, 1'b0, 8'h06, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    add(1'b1, 1'b0, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    add(1'b1, 1'b0, 8'h08, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0102030405060708);
    add_idle(8'h00);
`endif

    foreach (vecs[i]) apply(vecs[i]);

    // Every queued word must have been produced.
    chk("sb_leftover", 64'(sb.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
